// File: rtl/step_cmd_ctrl.sv
// Button conditioner, auto-stepper and arbiter feeding the digit-sequence FSM.
// Define HOLD_REPEAT_EN to add hold-to-repeat stepping in MAN mode.
module step_cmd_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int AUTO_PERIOD = 8,
  parameter int CNT_W       = 4
) (
  input  logic       dclk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  input  logic       btn_auto,
  output logic       up,
  output logic       down,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MAN     = 2'b00,
    AUTO_UP = 2'b01,
    AUTO_DN = 2'b10
  } mode_t;

  localparam int NB = 4;
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_LAST =
    CNT_W'(AUTO_PERIOD - 1);

  // bit order: 0 up, 1 down, 2 clr, 3 auto
  logic [NB-1:0] raw, s1, s2, deb, deb_d, prs;
  logic [CNT_W-1:0] dcnt [NB];

  assign raw = {btn_auto, btn_clr, btn_down, btn_up};
  assign prs = deb & ~deb_d;

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NB; i++)
        dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // one-hot event classes so the arbiter below is exclusive
  logic ev_clr, ev_auto, ev_step;

  assign ev_clr  = prs[2] | (prs[0] & prs[1]);
  assign ev_auto = prs[3] & ~ev_clr;
  assign ev_step = (prs[0] ^ prs[1])
                 & ~prs[2] & ~prs[3];

  mode_t            mode_q;
  mode_t            mode_nx;
  logic [CNT_W-1:0] tmr;
  logic             rep_up, rep_dn;

  always_comb begin
    mode_nx = MAN;
    unique case (mode_q)
      MAN:     mode_nx = AUTO_UP;
      AUTO_UP: mode_nx = AUTO_DN;
      default: mode_nx = MAN;
    endcase
  end

`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(2 * AUTO_PERIOD - 1);
  localparam logic [CNT_W-1:0] REP_RLD =
    CNT_W'(AUTO_PERIOD);

  logic             rep_arm, rep_dir, held;
  logic             rep_fire;
  logic [CNT_W-1:0] rep;

  assign held = rep_dir ? (deb[1] & ~deb[0])
                        : (deb[0] & ~deb[1]);
  assign rep_fire = rep_arm & held
                  & (rep == REP_LAST);
  assign rep_up = rep_fire & ~rep_dir;
  assign rep_dn = rep_fire & rep_dir;

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      rep_arm <= 1'b0;
      rep_dir <= 1'b0;
      rep     <= '0;
    end else if (ev_clr | ev_auto) begin
      rep_arm <= 1'b0;
      rep     <= '0;
    end else if (ev_step) begin
      rep_arm <= 1'b1;
      rep_dir <= prs[1];
      rep     <= '0;
    end else if (rep_arm & held) begin
      rep <= rep_fire ? REP_RLD : rep + 1'b1;
    end else begin
      rep_arm <= 1'b0;
      rep     <= '0;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      up     <= 1'b0;
      down   <= 1'b0;
      mode_q <= MAN;
      tmr    <= '0;
    end else begin
      up   <= 1'b0;
      down <= 1'b0;
      unique case (1'b1)
        ev_clr: begin
          up     <= 1'b1;
          down   <= 1'b1;
          mode_q <= MAN;
          tmr    <= '0;
        end
        ev_auto: begin
          mode_q <= mode_nx;
          tmr    <= '0;
        end
        ev_step: begin
          up     <= prs[0];
          down   <= prs[1];
          mode_q <= MAN;
          tmr    <= '0;
        end
        default: begin
          if (mode_q == MAN) begin
            tmr  <= '0;
            up   <= rep_up;
            down <= rep_dn;
          end else if (tmr == TMR_LAST) begin
            tmr  <= '0;
            up   <= (mode_q == AUTO_UP);
            down <= (mode_q == AUTO_DN);
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
      endcase
    end
  end

  assign mode = mode_q;

endmodule
